drive_ramp_sequencer: RTL and testbench
=======================================

# drive_ramp_sequencer

Sequences the enables of a segmented large output driver: a bank of NSEG parallel x16 inverter segments driving one heavy net. When the level request changes, segments switch on or off one at a time at a programmable interval, limiting di/dt and supply bounce on VDD/VSS. The block sits directly upstream of the driver bank, and each SEG_EN bit gates one segment.

## Interface
- NSEG, 16: number of driver segments; legal range is 2..32.
- STEP_W, 4: width of the step-interval input.
- CLK  input  1  rising-edge clock.
- RN  input  1  reset; asynchronous, active-low.
- VDD, VSS  inout  1  supply pins; no logic function.
- EN  input  1  requested drive level; 1 = all segments on, 0 = all off. Sampled on CLK.
- STEP  input  STEP_W  minimum spacing between segment changes, in cycles, minus 1.
- SEG_EN  output  NSEG  thermometer-coded segment enables; LSB switches on first.
- BUSY  output  1  high while the segment count differs from the requested level.
- FULL  output  1  high when all NSEG segments are enabled.
- DONE  output  1  one-cycle pulse on the edge where a ramp completes.

## Operation
- State:
  - cnt: number of enabled segments, 0..NSEG, width $clog2(NSEG+1).
  - tmr: interval timer, width STEP_W.
  - FSM states: OFF, RAMP_UP, ON, RAMP_DOWN.
- SEG_EN[i] = (i < cnt). The output is registered; no combinational path from EN.
- Step rule: a step may occur only on an edge where tmr == 0.
  - A step changes cnt by exactly ±1 and reloads tmr with the STEP value sampled on that same edge.
  - Otherwise tmr decrements, and holds at 0 once it reaches 0.
  - Consequence: any two SEG_EN changes are at least STEP+1 cycles apart, including across direction reversals.
- FSM transitions:
  - OFF -> RAMP_UP when EN=1.
  - RAMP_UP -> ON when a step makes cnt = NSEG.
  - ON -> RAMP_DOWN when EN=0.
  - RAMP_DOWN -> OFF when a step makes cnt = 0.
  - RAMP_UP <-> RAMP_DOWN when EN opposes the current direction. The reversal does not reload tmr; the next step in the new direction waits for tmr == 0.
- Step direction on an edge is taken from EN sampled on that edge. Increments stop at NSEG and decrements stop at 0, so cnt never wraps.
- BUSY = state is RAMP_UP or RAMP_DOWN. FULL = (cnt == NSEG).
- DONE is asserted for the one cycle after the edge that enters ON or OFF. A ramp that reverses and returns to its starting level also pulses DONE.
- Changing STEP mid-ramp takes effect at the next reload; an in-flight tmr value is unaffected.
- Reset (RN low) forces, immediately and without waiting for CLK:
  - cnt=0, tmr=0, state=OFF
  - SEG_EN=0, BUSY=0, FULL=0, DONE=0
- Releasing RN while EN=1 starts RAMP_UP on the first CLK edge after release.

## Timing
- Latency from OFF or ON with tmr == 0: the first segment change is on the same edge that samples the new EN value.
- Full ramp time is (NSEG-1)*(STEP+1)+1 edges. With NSEG=16 and STEP=3, SEG_EN goes from 0x0001 at edge 0 to 0xFFFF at edge 60.
- STEP=0 gives one segment per cycle; 16 segments take 16 edges.
- EN toggling faster than the step interval is legal. cnt tracks EN at no more than one step per STEP+1 cycles.

## Structure
- Shared package holds:
  - the state enum {OFF, RAMP_UP, ON, RAMP_DOWN};
  - the NSEG default;
  - a function mapping cnt to the thermometer code.
- One sub-module, drive_ramp_timer, holds the interval counter (load, count down, hold at zero). It has a tick output asserted when tmr == 0.
- Top level holds the FSM, cnt, and the output registers.

## Test plan
- Ramp up: reset, STEP=3, EN 0->1 sampled at edge 0.
  - SEG_EN 0x0001 at edge 0, 0x0003 at edge 4, 0xFFFF at edge 60.
  - DONE high for exactly one cycle after edge 60; FULL=1 and BUSY=0 from then on.
- Ramp down: from ON, EN=0 at edge 0, STEP=1.
  - SEG_EN 0x7FFF at edge 0, 0x3FFF at edge 2, 0x0000 at edge 30.
  - One DONE pulse.
- Reversal: STEP=3, EN=1 at edge 0, then EN=0 from edge 10.
  - cnt=3 at edge 8, cnt=2 at edge 12, cnt=0 at edge 20.
  - No SEG_EN change on edges 9-11; DONE pulse after edge 20.
- Async reset mid-ramp: RN low between edges with cnt=7.
  - SEG_EN=0, BUSY=0 before the next edge.
  - After release with EN=1, SEG_EN=0x0001 on the first edge.
- STEP=0: EN=1 gives SEG_EN 0x0001..0xFFFF on 16 consecutive edges.
- STEP change mid-ramp: STEP=7 changed to STEP=0 after one step. The next step follows 8 cycles after the previous one; steps after that are 1 cycle apart.

Source files
------------

// File: rtl/drive_ramp_sequencer_pkg.sv
// Shared types and helpers for the segmented-driver ramp sequencer.
`timescale 1ns/1ps
package drive_ramp_sequencer_pkg;

  // Default number of driver segments, and the largest supported bank.
  localparam int NSEG_DEF  = 16;
  localparam int SEG_MAX   = 32;
  localparam int CNT_MAX_W = 6;   // $clog2(SEG_MAX + 1)

  // Sequencer states: idle low, ramping up, idle high, ramping down.
  typedef enum logic [1:0] {
    OFF       = 2'd0,
    RAMP_UP   = 2'd1,
    ON        = 2'd2,
    RAMP_DOWN = 2'd3
  } state_t;

  // Thermometer code: bit i is set when i < n, so the LSB segment is first on.
  function automatic logic [SEG_MAX-1:0] thermo(input logic [CNT_MAX_W-1:0] n);
    logic [SEG_MAX-1:0] t;
    t = '0;
    for (int i = 0; i < SEG_MAX; i++) begin
      t[i] = (i < int'(n));
    end
    return t;
  endfunction

endpackage

// File: rtl/drive_ramp_timer.sv
// Step-interval timer: loads on a step, counts down, holds at zero.
`timescale 1ns/1ps
module drive_ramp_timer #(
  parameter int STEP_W = 4
) (
  input  logic              clk,
  input  logic              rn,
  input  logic              load,
  input  logic [STEP_W-1:0] load_val,
  output logic              tick
);

  logic [STEP_W-1:0] tmr;

  // Interval counter: reload on a step, otherwise decrement down to zero.
  // NOTE: sequential state is written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rn) begin
    if (!rn) begin
      tmr <= '0;
    end else if (load) begin
      tmr <= load_val;
    end else if (tmr != '0) begin
      tmr <= tmr - STEP_W'(1);
    end
  end

  // A step is allowed only once the interval has fully elapsed.
  assign tick = (tmr == '0);

endmodule

// File: rtl/drive_ramp_sequencer.sv
// Ramps a bank of driver segment enables on/off one segment per interval.
`timescale 1ns/1ps
module drive_ramp_sequencer
  import drive_ramp_sequencer_pkg::*;
#(
  parameter int NSEG   = NSEG_DEF,
  parameter int STEP_W = 4
) (
  input  logic              clk,
  input  logic              rn,
  inout  wire               vdd,
  inout  wire               vss,
  input  logic              en,
  input  logic [STEP_W-1:0] step,
  output logic [NSEG-1:0]   seg_en,
  output logic              busy,
  output logic              full,
  output logic              done
);

  localparam int            CW       = $clog2(NSEG + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(NSEG);

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [NSEG-1:0] seg_nxt;
  logic            tick;
  logic            step_up, step_dn;
  logic            enter_idle;

  // Supply pins carry no logic; they are only tied off here.
  wire unused_supply = vdd | vss;

  drive_ramp_timer #(
    .STEP_W (STEP_W)
  ) u_timer (
    .clk      (clk),
    .rn       (rn),
    .load     (step_up | step_dn),
    .load_val (step),
    .tick     (tick)
  );

  // Step decision: direction from the sampled level request, gated by the timer.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    step_up = tick && en && (cnt != CNT_FULL);
    step_dn = tick && !en && (cnt != '0);
    cnt_nxt = cnt;
    if (step_up) begin
      cnt_nxt = cnt + CW'(1);
    end else if (step_dn) begin
      cnt_nxt = cnt - CW'(1);
    end
  end

  // Next-state logic; reversals switch direction without touching the timer.
  always_comb begin
    state_nxt = state;
    case (state)
      OFF: begin
        if (en) state_nxt = RAMP_UP;
      end
      RAMP_UP: begin
        if (!en)                    state_nxt = (cnt_nxt == '0) ? OFF : RAMP_DOWN;
        else if (cnt_nxt == CNT_FULL) state_nxt = ON;
      end
      ON: begin
        if (!en) state_nxt = RAMP_DOWN;
      end
      RAMP_DOWN: begin
        if (en)                 state_nxt = (cnt_nxt == CNT_FULL) ? ON : RAMP_UP;
        else if (cnt_nxt == '0) state_nxt = OFF;
      end
      default: state_nxt = OFF;
    endcase
  end

  // Decode the next count and detect arrival at either idle level.
  always_comb begin
    seg_nxt    = NSEG'(thermo(CNT_MAX_W'(cnt_nxt)));
    enter_idle = ((state_nxt == ON)  && (state != ON)) ||
                 ((state_nxt == OFF) && (state != OFF));
  end

  // State, count and all outputs are registered; nothing reaches them from en directly.
  always_ff @(posedge clk or negedge rn) begin
    if (!rn) begin
      state  <= OFF;
      cnt    <= '0;
      seg_en <= '0;
      busy   <= 1'b0;
      full   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      seg_en <= seg_nxt;
      busy   <= (state_nxt == RAMP_UP) || (state_nxt == RAMP_DOWN);
      full   <= (cnt_nxt == CNT_FULL);
      done   <= enter_idle;
    end
  end

endmodule

// File: tb/tb_drive_ramp_sequencer.sv
// Directed scoreboard bench for drive_ramp_sequencer (NSEG=16, STEP_W=4).
`timescale 1ns/1ps
module tb_drive_ramp_sequencer;

  localparam int NSEG   = 16;
  localparam int STEP_W = 4;

  typedef struct {
    string       tag;
    int          at;
    logic [15:0] seg;
    logic        busy;
    logic        full;
    logic        done;
  } exp_t;

  logic              clk;
  logic              rn;
  logic              en;
  logic [STEP_W-1:0] step;
  logic [NSEG-1:0]   seg_en;
  logic              busy, full, done;
  wire               vdd = 1'b1;
  wire               vss = 1'b0;

  int   checks  = 0;
  int   errors  = 0;
  int   edge_no = -1;
  exp_t sb[$];

  drive_ramp_sequencer #(
    .NSEG   (NSEG),
    .STEP_W (STEP_W)
  ) dut (
    .clk    (clk),
    .rn     (rn),
    .vdd    (vdd),
    .vss    (vss),
    .en     (en),
    .step   (step),
    .seg_en (seg_en),
    .busy   (busy),
    .full   (full),
    .done   (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Expected state at edge k of a test whose edge 0 is 'base'.
  task automatic push_exp(input string name, input int base, input int k,
                          input int cnt, input logic busy_e, input logic done_e);
    logic [31:0] t;
    t = (32'd1 << cnt) - 32'd1;
    sb.push_back('{tag: $sformatf("%s_e%0d", name, k), at: base + k,
                   seg: t[15:0], busy: busy_e, full: (cnt == NSEG), done: done_e});
  endtask

  // Scoreboard consumer: 1 ns after each rising edge, compare due entries.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      edge_no++;
      while (sb.size() > 0 && sb[0].at == edge_no) begin
        e = sb.pop_front();
        check({e.tag, ".seg"},  32'(seg_en), 32'(e.seg));
        check({e.tag, ".busy"}, 32'(busy),   32'(e.busy));
        check({e.tag, ".full"}, 32'(full),   32'(e.full));
        check({e.tag, ".done"}, 32'(done),   32'(e.done));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at edge %0d", edge_no);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int c;

    // Reset state, checked before any clock edge.
    rn = 1'b1; en = 1'b0; step = 4'd3;
    #1 rn = 1'b0;
    #1;
    check("rst.seg",  32'(seg_en), 32'h0);
    check("rst.busy", 32'(busy),   32'h0);
    check("rst.full", 32'(full),   32'h0);
    check("rst.done", 32'(done),   32'h0);
    repeat (2) @(negedge clk);
    rn = 1'b1;
    repeat (2) @(negedge clk);
    check("idle.seg", 32'(seg_en), 32'h0);

    // Ramp up, STEP=3: one segment every 4 edges, full at edge 60.
    en = 1'b1; step = 4'd3; base = edge_no + 1;
    for (int k = 0; k <= 62; k++) begin
      c = (k / 4 + 1 > NSEG) ? NSEG : k / 4 + 1;
      push_exp("up", base, k, c, c != NSEG, k == 60);
    end
    repeat (63) @(negedge clk);
    repeat (4) @(negedge clk);

    // Ramp down from ON, STEP=1: one segment every 2 edges, empty at edge 30.
    en = 1'b0; step = 4'd1; base = edge_no + 1;
    for (int k = 0; k <= 32; k++) begin
      c = (15 - k / 2 < 0) ? 0 : 15 - k / 2;
      push_exp("down", base, k, c, c != 0, k == 30);
    end
    repeat (33) @(negedge clk);
    repeat (4) @(negedge clk);

    // Reversal: up from edge 0, request drops from edge 10; timer is not reloaded.
    en = 1'b1; step = 4'd3; base = edge_no + 1;
    for (int k = 0; k <= 22; k++) begin
      if (k < 12) c = k / 4 + 1;
      else        c = (2 - (k - 12) / 4 < 0) ? 0 : 2 - (k - 12) / 4;
      push_exp("rev", base, k, c, c != 0, k == 20);
    end
    repeat (10) @(negedge clk);
    en = 1'b0;
    repeat (13) @(negedge clk);
    repeat (4) @(negedge clk);

    // Async reset mid-ramp with cnt=7, then restart on the first edge after release.
    en = 1'b1; step = 4'd3; base = edge_no + 1;
    for (int k = 0; k <= 25; k++) push_exp("pre_rst", base, k, k / 4 + 1, 1'b1, 1'b0);
    repeat (26) @(negedge clk);
    #2 rn = 1'b0;
    #1;
    check("arst.seg",  32'(seg_en), 32'h0);
    check("arst.busy", 32'(busy),   32'h0);
    check("arst.full", 32'(full),   32'h0);
    @(negedge clk);
    check("arst_hold.seg", 32'(seg_en), 32'h0);
    rn = 1'b1; base = edge_no + 1;
    for (int k = 0; k <= 4; k++) push_exp("post_rst", base, k, k / 4 + 1, 1'b1, 1'b0);
    repeat (5) @(negedge clk);

    // STEP=0: one segment per edge, full on the 16th edge.
    rn = 1'b0; en = 1'b1; step = 4'd0;
    @(negedge clk);
    rn = 1'b1; base = edge_no + 1;
    for (int k = 0; k <= 17; k++) begin
      c = (k + 1 > NSEG) ? NSEG : k + 1;
      push_exp("fast", base, k, c, c != NSEG, k == 15);
    end
    repeat (18) @(negedge clk);

    // STEP 7 -> 0 after the first step: next step 8 edges later, then every edge.
    rn = 1'b0; en = 1'b1; step = 4'd7;
    @(negedge clk);
    rn = 1'b1; base = edge_no + 1;
    for (int k = 0; k <= 24; k++) begin
      if (k < 8) c = 1;
      else       c = (k - 6 > NSEG) ? NSEG : k - 6;
      push_exp("stepchg", base, k, c, c != NSEG, k == 22);
    end
    @(negedge clk);
    step = 4'd0;
    repeat (24) @(negedge clk);

    check("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
